// File: rtl/regcr_pkg.sv
// regcr_pkg: shared widths, entry count, clear-sequencer state encoding,
// per-field write-enable indices and the read-port result record used by
// the capability register file (regcr) and its tag-scrub sequencer.
package regcr_pkg;

    // Widths of the address-like and data-like capability fields.
    localparam int SIZE_ADDR   = 32;
    localparam int SIZE_DATA   = 16;

    // Register index width and default number of entries.
    localparam int HBIT_TGT_CR = 2;
    localparam int SIZE_TGT_CR = HBIT_TGT_CR + 1;
    localparam int NUM_CR_DEF  = 2 ** (HBIT_TGT_CR + 1);

    // Bulk tag-invalidate sequencer states.
    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_SCAN = 1'b1
    } clr_state_e;

    // Bit positions of the per-field write enables.
    localparam int FLD_BASE  = 0;
    localparam int FLD_LEN   = 1;
    localparam int FLD_CUR   = 2;
    localparam int FLD_PERMS = 3;
    localparam int FLD_ATTR  = 4;
    localparam int FLD_TAG   = 5;
    localparam int NUM_FLD   = 6;

    // One read port's worth of capability fields.
    typedef struct packed {
        logic [SIZE_ADDR-1:0] base;
        logic [SIZE_ADDR-1:0] len;
        logic [SIZE_ADDR-1:0] cur;
        logic [SIZE_DATA-1:0] perms;
        logic [SIZE_DATA-1:0] attr;
        logic                 tag;
    } cr_rd_t;

endpackage

// File: rtl/regcr_clr_seq.sv
// regcr_clr_seq: bulk tag-invalidate sequencer.
// A request marks every entry pending (architectural revoke in one cycle),
// then walks the entries one per cycle, strobing a physical tag clear for
// each entry that is still pending.
// Ports:
//   iw_clk, iw_rst      clock, asynchronous active-high reset
//   iw_clr_req          bulk invalidate request (one-cycle pulse)
//   iw_we_tag           writeback tag write enable
//   iw_tag_addr         writeback tag write target
//   ow_clr_stb[NUM_CR]  per-entry "clear stored tag now" strobe
//   ow_pend[NUM_CR]     pending-clear bitmap
//   ow_clr_busy         scan in progress (registered state)
//   ow_clr_done         one-cycle pulse after the last entry is scanned
module regcr_clr_seq
    import regcr_pkg::*;
#(
    parameter int NUM_CR = NUM_CR_DEF
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic                   iw_clr_req,
    input  logic                   iw_we_tag,
    input  logic [SIZE_TGT_CR-1:0] iw_tag_addr,
    output logic [NUM_CR-1:0]      ow_clr_stb,
    output logic [NUM_CR-1:0]      ow_pend,
    output logic                   ow_clr_busy,
    output logic                   ow_clr_done
);

    localparam int                IDX_W    = $clog2(NUM_CR);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CR - 1);

    clr_state_e          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_CR-1:0]   r_pend;
    logic                r_done;

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_state <= CLR_IDLE;
            r_idx   <= '0;
            r_pend  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CLR_IDLE: begin
                    if (iw_clr_req) begin
                        r_state <= CLR_SCAN;
                        r_pend  <= '1;
                        r_idx   <= '0;
                    end
                end
                CLR_SCAN: begin
                    // A new request restarts the walk; the aborted scan
                    // never reports done.
                    if (iw_clr_req) begin
                        r_pend <= '1;
                        r_idx  <= '0;
                    end else begin
                        r_pend[r_idx] <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= CLR_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= CLR_IDLE;
            endcase
            // A tag rewritten by writeback is no longer revoked; this comes
            // last so it also wins over a request in the same cycle.
            for (int i = 0; i < NUM_CR; i++) begin
                if (iw_we_tag && (iw_tag_addr == SIZE_TGT_CR'(i)))
                    r_pend[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        ow_clr_stb = '0;
        for (int i = 0; i < NUM_CR; i++) begin
            ow_clr_stb[i] = (r_state == CLR_SCAN) && (r_idx == IDX_W'(i)) && r_pend[i];
        end
    end

    assign ow_pend     = r_pend;
    assign ow_clr_busy = (r_state == CLR_SCAN);
    assign ow_clr_done = r_done;

endmodule

// File: rtl/regcr.sv
// regcr: capability register file fed by the writeback CR-control bus.
// Each entry holds base, len, cur, perms, attr and a tag. Fields are written
// independently; two combinational read ports return storage with per-field
// same-cycle write bypass. The effective tag is masked by the pending-clear
// bitmap of the bulk invalidate sequencer.
// Ports:
//   iw_clk, iw_rst                   clock, asynchronous active-high reset
//   iw_cr_write_addr                 write target entry
//   iw_cr_we_<f> / iw_cr_<f>         per-field write enable / data
//   iw_rd_a_addr, iw_rd_b_addr       read port addresses
//   ow_rd_a_<f>, ow_rd_b_<f>         read port fields (tag is effective tag)
//   iw_clr_req                       bulk tag-invalidate request
//   ow_clr_busy, ow_clr_done         scrub status
module regcr
    import regcr_pkg::*;
#(
    parameter int NUM_CR = NUM_CR_DEF
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic [SIZE_TGT_CR-1:0] iw_cr_write_addr,
    input  logic                   iw_cr_we_base,
    input  logic [SIZE_ADDR-1:0]   iw_cr_base,
    input  logic                   iw_cr_we_len,
    input  logic [SIZE_ADDR-1:0]   iw_cr_len,
    input  logic                   iw_cr_we_cur,
    input  logic [SIZE_ADDR-1:0]   iw_cr_cur,
    input  logic                   iw_cr_we_perms,
    input  logic [SIZE_DATA-1:0]   iw_cr_perms,
    input  logic                   iw_cr_we_attr,
    input  logic [SIZE_DATA-1:0]   iw_cr_attr,
    input  logic                   iw_cr_we_tag,
    input  logic                   iw_cr_tag,
    input  logic [SIZE_TGT_CR-1:0] iw_rd_a_addr,
    input  logic [SIZE_TGT_CR-1:0] iw_rd_b_addr,
    output logic [SIZE_ADDR-1:0]   ow_rd_a_base,
    output logic [SIZE_ADDR-1:0]   ow_rd_a_len,
    output logic [SIZE_ADDR-1:0]   ow_rd_a_cur,
    output logic [SIZE_DATA-1:0]   ow_rd_a_perms,
    output logic [SIZE_DATA-1:0]   ow_rd_a_attr,
    output logic                   ow_rd_a_tag,
    output logic [SIZE_ADDR-1:0]   ow_rd_b_base,
    output logic [SIZE_ADDR-1:0]   ow_rd_b_len,
    output logic [SIZE_ADDR-1:0]   ow_rd_b_cur,
    output logic [SIZE_DATA-1:0]   ow_rd_b_perms,
    output logic [SIZE_DATA-1:0]   ow_rd_b_attr,
    output logic                   ow_rd_b_tag,
    input  logic                   iw_clr_req,
    output logic                   ow_clr_busy,
    output logic                   ow_clr_done
);

    logic [SIZE_ADDR-1:0] r_base  [NUM_CR];
    logic [SIZE_ADDR-1:0] r_len   [NUM_CR];
    logic [SIZE_ADDR-1:0] r_cur   [NUM_CR];
    logic [SIZE_DATA-1:0] r_perms [NUM_CR];
    logic [SIZE_DATA-1:0] r_attr  [NUM_CR];
    logic [NUM_CR-1:0]    r_tag;

    logic [NUM_CR-1:0]    clr_stb;
    logic [NUM_CR-1:0]    pend;
    logic [NUM_FLD-1:0]   we_fld;
    cr_rd_t               rd_a;
    cr_rd_t               rd_b;

    always_comb begin
        we_fld            = '0;
        we_fld[FLD_BASE]  = iw_cr_we_base;
        we_fld[FLD_LEN]   = iw_cr_we_len;
        we_fld[FLD_CUR]   = iw_cr_we_cur;
        we_fld[FLD_PERMS] = iw_cr_we_perms;
        we_fld[FLD_ATTR]  = iw_cr_we_attr;
        we_fld[FLD_TAG]   = iw_cr_we_tag;
    end

    regcr_clr_seq #(
        .NUM_CR (NUM_CR)
    ) u_clr_seq (
        .iw_clk      (iw_clk),
        .iw_rst      (iw_rst),
        .iw_clr_req  (iw_clr_req),
        .iw_we_tag   (iw_cr_we_tag),
        .iw_tag_addr (iw_cr_write_addr),
        .ow_clr_stb  (clr_stb),
        .ow_pend     (pend),
        .ow_clr_busy (ow_clr_busy),
        .ow_clr_done (ow_clr_done)
    );

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int i = 0; i < NUM_CR; i++) begin
                r_base[i]  <= '0;
                r_len[i]   <= '0;
                r_cur[i]   <= '0;
                r_perms[i] <= '0;
                r_attr[i]  <= '0;
            end
            r_tag <= '0;
        end else begin
            for (int i = 0; i < NUM_CR; i++) begin
                if (iw_cr_write_addr == SIZE_TGT_CR'(i)) begin
                    if (we_fld[FLD_BASE])  r_base[i]  <= iw_cr_base;
                    if (we_fld[FLD_LEN])   r_len[i]   <= iw_cr_len;
                    if (we_fld[FLD_CUR])   r_cur[i]   <= iw_cr_cur;
                    if (we_fld[FLD_PERMS]) r_perms[i] <= iw_cr_perms;
                    if (we_fld[FLD_ATTR])  r_attr[i]  <= iw_cr_attr;
                end
                // Scrub first, writeback tag second: the write wins on a tie.
                if (clr_stb[i])
                    r_tag[i] <= 1'b0;
                if (we_fld[FLD_TAG] && (iw_cr_write_addr == SIZE_TGT_CR'(i)))
                    r_tag[i] <= iw_cr_tag;
            end
        end
    end

    // Storage lookup followed by per-field bypass of the in-flight write.
    // The bypassed tag ignores pend because a tag write clears it.
    function automatic cr_rd_t rd_port(input logic [SIZE_TGT_CR-1:0] addr);
        cr_rd_t r;
        logic   hit;
        r = '0;
        for (int i = 0; i < NUM_CR; i++) begin
            if (addr == SIZE_TGT_CR'(i)) begin
                r.base  = r_base[i];
                r.len   = r_len[i];
                r.cur   = r_cur[i];
                r.perms = r_perms[i];
                r.attr  = r_attr[i];
                r.tag   = r_tag[i] & ~pend[i];
            end
        end
        hit = (addr == iw_cr_write_addr);
        if (hit && we_fld[FLD_BASE])  r.base  = iw_cr_base;
        if (hit && we_fld[FLD_LEN])   r.len   = iw_cr_len;
        if (hit && we_fld[FLD_CUR])   r.cur   = iw_cr_cur;
        if (hit && we_fld[FLD_PERMS]) r.perms = iw_cr_perms;
        if (hit && we_fld[FLD_ATTR])  r.attr  = iw_cr_attr;
        if (hit && we_fld[FLD_TAG])   r.tag   = iw_cr_tag;
        return r;
    endfunction

    always_comb begin
        rd_a = rd_port(iw_rd_a_addr);
        rd_b = rd_port(iw_rd_b_addr);
    end

    assign ow_rd_a_base  = rd_a.base;
    assign ow_rd_a_len   = rd_a.len;
    assign ow_rd_a_cur   = rd_a.cur;
    assign ow_rd_a_perms = rd_a.perms;
    assign ow_rd_a_attr  = rd_a.attr;
    assign ow_rd_a_tag   = rd_a.tag;
    assign ow_rd_b_base  = rd_b.base;
    assign ow_rd_b_len   = rd_b.len;
    assign ow_rd_b_cur   = rd_b.cur;
    assign ow_rd_b_perms = rd_b.perms;
    assign ow_rd_b_attr  = rd_b.attr;
    assign ow_rd_b_tag   = rd_b.tag;

endmodule

// File: doc/regcr.md
# regcr

Capability register file at the receiving end of the writeback CR-control bus driven by `stg_wb`. It holds the following fields for each capability register: base, len, cur, perms, attr and tag. It applies per-field writes and serves two combinational read ports with same-cycle write bypass. A bulk tag-invalidate sequencer revokes all capabilities architecturally in one cycle and physically scrubs the tags one entry per cycle.

## Interface
- `NUM_CR`, default 2**(`HBIT_TGT_CR`+1), number of entries. Defined in `src/cr.vh`, minimum 4.
- `iw_clk`  in  1  clock, rising edge.
- `iw_rst`  in  1  reset, asynchronous, active-high.
- `iw_cr_write_addr`  in  `SIZE_TGT_CR`  target entry for the write.
- `iw_cr_we_base`/`iw_cr_base`  in  1/`SIZE_ADDR`  base write enable/data.
- `iw_cr_we_len`/`iw_cr_len`  in  1/`SIZE_ADDR`  len write enable/data.
- `iw_cr_we_cur`/`iw_cr_cur`  in  1/`SIZE_ADDR`  cur write enable/data.
- `iw_cr_we_perms`/`iw_cr_perms`  in  1/`SIZE_DATA`  perms write enable/data.
- `iw_cr_we_attr`/`iw_cr_attr`  in  1/`SIZE_DATA`  attr write enable/data.
- `iw_cr_we_tag`/`iw_cr_tag`  in  1/1  tag write enable/data.
- `iw_rd_a_addr`, `iw_rd_b_addr`  in  `SIZE_TGT_CR`  read port addresses.
- `ow_rd_a_base`/`len`/`cur`  out  `SIZE_ADDR`  port A address fields. Port B has the same fields under `ow_rd_b_*`.
- `ow_rd_a_perms`/`attr`  out  `SIZE_DATA`  port A data fields. Port B has the same fields under `ow_rd_b_*`.
- `ow_rd_a_tag`, `ow_rd_b_tag`  out  1  effective tag for each port.
- `iw_clr_req`  in  1  bulk tag-invalidate request, one-cycle pulse.
- `ow_clr_busy`  out  1  scrub in progress.
- `ow_clr_done`  out  1  one-cycle pulse when the scrub completes.

## Operation
- Storage: `NUM_CR` entries × {base, len, cur, perms, attr, tag}, plus a pending-clear bitmap `r_pend[NUM_CR]`.
- Write: on a clock edge, each field whose enable is high is written at `iw_cr_write_addr`. Fields are independent, and any subset may be written.
- Read: combinational from storage, with per-field bypass. If a field's enable is high and the write address equals the read address, the incoming data is returned for that field.
- Effective tag = (bypassed tag) AND NOT `r_pend[addr]`. If `iw_cr_we_tag` is high for the read address, the effective tag equals `iw_cr_tag`, regardless of `r_pend`.
- Clear FSM states:
  - IDLE: `iw_clr_req` → SCAN, with `r_pend` ← all ones and `r_idx` ← 0.
  - SCAN: if `r_pend[r_idx]` is set, the stored tag[r_idx] ← 0 and `r_pend[r_idx]` ← 0. Then `r_idx`++. When `r_idx` == NUM_CR-1, → IDLE and `r_done` is set.
- A tag write (`iw_cr_we_tag`) always sets stored tag[addr] ← `iw_cr_tag` and clears `r_pend[addr]`. The scrub never overwrites an entry rewritten after the request.
- Priority in the same cycle at the same index: a writeback tag write beats a scrub clear.
- `iw_clr_req` during SCAN restarts the scan: `r_pend` ← all ones and `r_idx` ← 0, with no done pulse for the aborted scan.
- `iw_clr_req` together with `iw_cr_we_tag`: the request is applied first, then the write. The written entry's pend bit ends at 0 and its tag equals the written value.
- Only tags are cleared. base, len, cur, perms and attr are untouched by the sequencer.

## Timing
- Reset (asynchronous): all fields 0, all tags 0, `r_pend` 0, `r_idx` 0, state IDLE. `ow_clr_busy` = 0, `ow_clr_done` = 0.
- Read outputs after reset: all 0.
- Write latency: visible on reads in the same cycle through the bypass, and from storage from the next cycle.
- `iw_clr_req` accepted at edge t:
  - Effective tags read 0 from cycle t+1.
  - `ow_clr_busy` is high for cycles t+1..t+NUM_CR.
  - `ow_clr_done` is high in cycle t+NUM_CR+1 only.
- `ow_clr_busy` = (state == SCAN), registered. `ow_clr_done` is registered.
- `r_idx` wraps modulo NUM_CR and never goes out of range.

## Structure
- `src/cr.vh` holds `NUM_CR`, the clear FSM state encodings, and the field index constants. `src/sizes.vh` holds the widths.
- Sub-module `regcr_clr_seq` contains the FSM, `r_idx`, `r_pend`, busy and done. It exports a per-entry clear strobe and the pend vector. The `regcr` top holds the storage, write logic and read bypass.

## Test plan
- Reset with an inactive clock → all read fields 0, busy 0, done 0.
- Write base=0x100, len=0x40, tag=1 to CR2 → port A at CR2 shows these values in the same cycle (bypass) and the next cycle. Port B at CR1 stays 0.
- Write perms only (0x7) to CR2 while its base is 0x100 → base stays 0x100 and perms becomes 0x7.
- Set tags on CR0..CR3, pulse `iw_clr_req` → all effective tags read 0 from t+1. busy is high for NUM_CR cycles, done pulses once at t+NUM_CR+1, and the other fields are unchanged.
- During SCAN at `r_idx`=1, write tag=1 to CR3 → CR3 reads 1 after scan completion; all other tags read 0.
- Reissue `iw_clr_req` mid-scan → `r_idx` restarts at 0. busy extends to NUM_CR cycles after the second request, with a single done pulse. Assert reset mid-scan → busy drops immediately and all tags read 0.
